// File: rtl/rvc_dmem_arb_mc.sv
// Round-robin arbitrated, single-port shared data memory for multi-core rvc_asap with load extension.
// Optional per-core stall counters are enabled by defining RVC_DMEM_ARB_STATS_EN.
module rvc_dmem_arb_mc #(
    parameter int          NUM_CORES   = 2,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                      Clock,
    input  logic                      Rst,
    input  logic [NUM_CORES-1:0]      ReqValid,
    input  logic [NUM_CORES-1:0]      ReqWrEn,
    input  logic [NUM_CORES*32-1:0]   ReqAddr,
    input  logic [NUM_CORES*32-1:0]   ReqWrData,
    input  logic [NUM_CORES*4-1:0]    ReqByteEn,
    input  logic [NUM_CORES-1:0]      ReqSignExt,
    output logic [NUM_CORES-1:0]      ReqReady,
    output logic [NUM_CORES-1:0]      RspValid,
    output logic [NUM_CORES*32-1:0]   RspRdData,
    output logic [NUM_CORES-1:0]      RspErr
`ifdef RVC_DMEM_ARB_STATS_EN
   ,output logic [NUM_CORES*16-1:0]   StallCnt
`endif
);

    localparam int          PW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]          mem [DEPTH_WORDS];
    logic [PW-1:0]        ptr;
    logic                 grantAny;
    logic [PW-1:0]        grantIdx;
    logic                 gWr;
    logic                 gSext;
    logic [31:0]          gAddr;
    logic [31:0]          gData;
    logic [3:0]           gBe;
    logic [31:0]          gOff;
    logic                 inRange;
    logic [AW-1:0]        wordIdx;
    logic [31:0]          loadData;
    logic [NUM_CORES-1:0] rspValidQ;
    logic [NUM_CORES-1:0] rspErrQ;

    function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [3:0] be,
                                               input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = 8'h0;
        h   = 16'h0;
        res = word;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                case (be)
                    4'b0001: b = word[7:0];
                    4'b0010: b = word[15:8];
                    4'b0100: b = word[23:16];
                    default: b = word[31:24];
                endcase
                res = {{24{sext & b[7]}}, b};
            end
            4'b0011, 4'b1100: begin
                h   = (be == 4'b0011) ? word[15:0] : word[31:16];
                res = {{16{sext & h[15]}}, h};
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Scan from the round-robin pointer upward; first valid core wins, nothing is granted in reset.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        ReqReady = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!grantAny && ReqValid[(int'(ptr) + i) % NUM_CORES]) begin
                grantAny = 1'b1;
                grantIdx = PW'((int'(ptr) + i) % NUM_CORES);
            end
        end
        if (!Rst) begin
            grantAny = 1'b0;
        end
        if (grantAny) begin
            ReqReady[grantIdx] = 1'b1;
        end
    end

    assign gWr      = ReqWrEn[grantIdx];
    assign gSext    = ReqSignExt[grantIdx];
    assign gAddr    = ReqAddr[32*int'(grantIdx) +: 32];
    assign gData    = ReqWrData[32*int'(grantIdx) +: 32];
    assign gBe      = ReqByteEn[4*int'(grantIdx) +: 4];
    assign gOff     = gAddr - BASE_ADDR;
    assign inRange  = ({1'b0, gOff} < SPAN);
    assign wordIdx  = gOff[AW+1:2];
    assign loadData = extendLoad(mem[wordIdx], gBe, gSext);

    always_ff @(posedge Clock) begin
        if (grantAny && gWr && inRange) begin
            for (int k = 0; k < 4; k++) begin
                if (gBe[k]) begin
                    mem[wordIdx][8*k +: 8] <= gData[8*k +: 8];
                end
            end
        end
    end

    // Loads and out-of-range accesses answer on the following cycle; in-range stores stay silent.
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            ptr       <= '0;
            rspValidQ <= '0;
            rspErrQ   <= '0;
            RspRdData <= '0;
        end else begin
            rspValidQ <= '0;
            rspErrQ   <= '0;
            if (grantAny) begin
                ptr <= (int'(grantIdx) == NUM_CORES - 1) ? '0 : grantIdx + 1'b1;
                if (!gWr || !inRange) begin
                    rspValidQ[grantIdx]                   <= 1'b1;
                    rspErrQ[grantIdx]                     <= !inRange;
                    RspRdData[32*int'(grantIdx) +: 32]    <= inRange ? loadData : 32'h0;
                end
            end
        end
    end

    // Masking with Rst drops a response whose cycle coincides with reset assertion.
    assign RspValid = rspValidQ & {NUM_CORES{Rst}};
    assign RspErr   = rspErrQ & {NUM_CORES{Rst}};

`ifdef RVC_DMEM_ARB_STATS_EN
    always_ff @(posedge Clock) begin
        for (int c = 0; c < NUM_CORES; c++) begin
            if (!Rst) begin
                StallCnt[16*c +: 16] <= 16'h0;
            end else if (ReqValid[c] && !ReqReady[c] && StallCnt[16*c +: 16] != 16'hFFFF) begin
                StallCnt[16*c +: 16] <= StallCnt[16*c +: 16] + 16'h1;
            end
        end
    end
`endif

endmodule
